// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. One full_adder cell processes one
// operand bit pair per cycle, LSB first, with the carry held in a register.
// {Cout,Sum} = A + B + Cin. Results appear WIDTH cycles after acceptance.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output Ovf.

// Single-bit full adder cell used as the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    // Holds the sum bits gathered so far; the bit being produced this cycle
    // is concatenated on top so the final word never needs an extra shift.
    logic [WIDTH-2:0]   res_r;
    logic [WIDTH-1:0]   res_cat_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic               last_s;
    logic               load_s;
    logic               shift_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign res_cat_s = {fa_sum_s, res_r};
    assign last_s    = (cnt_r == CNT_W'(WIDTH - 1));

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: start is honoured only outside SHIFT.
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Control decode: load/shift strobes and next values of the registered flags.
    always_comb begin
        load_s     = 1'b0;
        shift_s    = 1'b0;
        done_nxt_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                load_s = start;
            end
            SHIFT: begin
                shift_s    = 1'b1;
                done_nxt_s = last_s;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
        if (state_nxt_s == SHIFT) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // Datapath and registered outputs; Sum/Cout only move on the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            res_r   <= {(WIDTH-1){1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            Sum     <= {WIDTH{1'b0}};
            Cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            busy <= busy_nxt_s;
            done <= done_nxt_s;
            if (load_s) begin
                a_sh_r  <= A;
                b_sh_r  <= B;
                carry_r <= Cin;
                cnt_r   <= {CNT_W{1'b0}};
            end else if (shift_s) begin
                a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                carry_r <= fa_cout_s;
                cnt_r   <= cnt_r + CNT_W'(1);
                res_r   <= res_cat_s[WIDTH-1:1];
                if (last_s) begin
                    Sum  <= res_cat_s;
                    Cout <= fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
                    // Carry into the MSB is still in carry_r on the last bit.
                    Ovf  <= carry_r ^ fa_cout_s;
`endif
                end else begin
                    Sum  <= Sum;
                    Cout <= Cout;
                end
            end else begin
                a_sh_r  <= a_sh_r;
                b_sh_r  <= b_sh_r;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;
    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       busy;
    logic       done;
    logic [7:0] Sum;
    logic       Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       Ovf;
`endif

    int         checks;
    int         errors;
    logic [7:0] last_sum;
    logic       last_cout;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done after an accepting edge; outputs must hold and busy stay high until then.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            check("busy_shift", {31'd0, busy}, 32'd1);
            check("sum_hold", {24'd0, Sum}, {24'd0, last_sum});
            check("cout_hold", {31'd0, Cout}, {31'd0, last_cout});
        end
        if (lat == 0) begin
            check("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp_res);
        int lat;
        @(negedge clk);
        A = a; B = b; Cin = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_accept", {31'd0, busy}, 32'd1);
        check("done_accept", {31'd0, done}, 32'd0);
        wait_done(lat);
        check("latency", lat, 32'd8);
        check("busy_done", {31'd0, busy}, 32'd0);
        check("sum", {24'd0, Sum}, {24'd0, exp_res[7:0]});
        check("cout", {31'd0, Cout}, {31'd0, exp_res[8]});
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", {31'd0, Ovf}, {31'd0, (a[7] == b[7]) && (exp_res[7] != a[7])});
`endif
        last_sum  = exp_res[7:0];
        last_cout = exp_res[8];
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0;
        last_sum = 8'h00; last_cout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, Sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hand-computed directed vectors: {Cout,Sum}.
        do_op(8'h35, 8'h4A, 1'b0, 9'h07F);
        do_op(8'hFF, 8'h01, 1'b1, 9'h101);
        do_op(8'h7F, 8'h01, 1'b0, 9'h080);
        do_op(8'h80, 8'h80, 1'b0, 9'h100);
        do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        do_op(8'h00, 8'h00, 1'b1, 9'h001);
        do_op(8'hAA, 8'h55, 1'b0, 9'h0FF);
        do_op(8'hAA, 8'h55, 1'b1, 9'h100);

        // Start pulsed mid-SHIFT is ignored; start held into DONE chains the next op.
        @(negedge clk);
        A = 8'h35; B = 8'h4A; Cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                start = 1'b1; A = 8'h11;
            end
            if (i == 3) begin
                start = 1'b0;
            end
            if (i == 7) begin
                start = 1'b1; A = 8'h10; B = 8'h20; Cin = 1'b0;
            end
            if (i < 8) begin
                check("mid_done_low", {31'd0, done}, 32'd0);
                check("mid_sum_hold", {24'd0, Sum}, {24'd0, last_sum});
            end else begin
                check("mid_done", {31'd0, done}, 32'd1);
                check("mid_sum", {24'd0, Sum}, 32'h7F);
                check("mid_cout", {31'd0, Cout}, 32'd0);
                check("mid_busy_done", {31'd0, busy}, 32'd0);
            end
        end
        last_sum = 8'h7F; last_cout = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(lat);
        check("b2b_latency", lat, 32'd8);
        check("b2b_sum", {24'd0, Sum}, 32'h30);
        check("b2b_cout", {31'd0, Cout}, 32'd0);
        last_sum = 8'h30; last_cout = 1'b0;

        // Reset three cycles into an operation aborts it with no done pulse.
        @(negedge clk);
        A = 8'hFF; B = 8'h01; Cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {24'd0, Sum}, 32'd0);
        check("abort_cout", {31'd0, Cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_sum = 8'h00; last_cout = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 32'd0);
        do_op(8'h12, 8'h34, 1'b1, 9'h047);

        // Short pseudo-random sweep against the bench's own sum.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(255, 0));
            rb = 8'($urandom_range(255, 0));
            rc = 1'($urandom_range(1, 0));
            do_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
